pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
// - Parametrised, pipelined successor to half_adder: WIDTH-bit a+b+cin with carry chain split across STAGES registered slices.
// - valid/ready handshake on both sides; full throughput (1 op/cycle) under no backpressure.
// - Arithmetic building block for datapath units needing wide adds at high clock rate.
// PARAMETERS
// - WIDTH   32  operand/sum width in bits; WIDTH >= 1
// - STAGES  4   pipeline slices; 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0 (elaboration $error otherwise)
// PORTS
// - clk        in   1      rising-edge clock; sole clock domain
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      operand beat valid
// - in_ready   out  1      adder can accept operand beat this cycle
// - a          in   WIDTH  operand A (unsigned / two's complement)
// - b          in   WIDTH  operand B
// - cin        in   1      carry in
// - out_valid  out  1      result beat valid
// - out_ready  in   1      downstream accepts result this cycle
// - sum        out  WIDTH  (a+b+cin) mod 2^WIDTH
// - cout       out  1      unsigned carry out of bit WIDTH-1
// - ovf        out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
// BEHAVIOUR
// - Slice width SW = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*SW +: SW] with carry from stage k-1 (stage 0 uses cin).
// - Each stage register holds: valid bit, completed low sum bits, carry, remaining unprocessed upper a/b bits (operand skew).
// - Stage 0 captures on in_valid && in_ready; final stage register drives sum/cout/ovf/out_valid directly (no comb path a->sum).
// - Latency: STAGES cycles from input handshake to out_valid with out_ready held high.
// - Advance rule: adv[S-1] = valid[S-1] -> out_ready; adv[k] = !valid[k+1] || adv[k+1].
//   in_ready = !valid[0] || adv[0] (combinational from out_ready; no comb path from in_valid).
// - Stage k loads from k-1 when adv[k-1]; clears valid when it hands off and nothing moves in.
// - Bubbles collapse: a stalled output does not block upstream stages until they reach a full stage.
// - Stalled stage holds all contents stable; sum/cout/ovf stable while out_valid && !out_ready.
// - Simultaneous accept at input and emit at output in same cycle: both occur; occupancy unchanged.
// - Full pipe (STAGES valid) with out_ready=0: in_ready=0; no beat lost or duplicated.
// - Wrap-around: sum is modulo 2^WIDTH; cout carries the lost bit; ovf independent of cin sign interpretation (cin treated as +1).
// - Ordering: results emerge in strict acceptance order.
// - Reset: all valid bits cleared next edge; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 in first cycle after reset deasserts.
// - Reset mid-operation: in-flight beats discarded, never emitted; reset has priority over any handshake in that cycle.
// - No X propagation: data registers for invalid stages may hold stale values but outputs are gated to 0 when out_valid=0.
// - STAGES=1: single registered adder, latency 1, same handshake rules.
// TESTING
// - Reset: assert rst 2 cycles mid-stream with 3 beats in flight -> out_valid=0, sum=0, cout=0; none of those 3 beats ever emerge.
// - Latency/basic (WIDTH=32,STAGES=4): a=0x0000_0005,b=0x0000_0003,cin=0, out_ready=1 -> out_valid exactly 4 cycles later, sum=0x8, cout=0, ovf=0.
// - Full ripple: a=0xFFFF_FFFF,b=0,cin=1 -> sum=0, cout=1, ovf=0; a=0x7FFF_FFFF,b=1 -> sum=0x8000_0000, ovf=1, cout=0.
// - Throughput: 100 back-to-back random beats, out_ready=1 -> in_ready never low, 100 results in order, one per cycle, match a+b+cin reference model.
// - Backpressure: out_ready=0 for 10 cycles while in_valid=1 -> exactly 4 beats accepted, then in_ready=0; sum held stable; on release all drain in order.
// - Exhaustive small config (WIDTH=4,STAGES=2; WIDTH=3,STAGES=1): all 2^(2W+1) a/b/cin combos with random out_ready -> every {cout,sum} and ovf correct.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit a+b+cin with the carry chain cut into STAGES registered slices.
// Each stage carries the finished low sum bits, its carry-out and the operands downstream.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = (STAGES == 0) ? WIDTH : WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % ((STAGES == 0) ? 1 : STAGES)) != 0)
  begin : g_param_check
    $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  // adv[k]: the register after stage k is free or will be vacated this cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k+1] || adv[k+1];
    end
  end

  assign in_ready = !valid_q[0] || adv[0];

  always_comb begin
    logic [WIDTH-1:0] src_a, src_b, src_sum;
    logic             src_c, src_v, ld;
    logic [SW:0]      slice;
    int               km1;
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    src_c   = 1'b0;
    src_v   = 1'b0;
    ld      = 1'b0;
    slice   = '0;
    km1     = 0;
    for (int k = 0; k < int'(STAGES); k++) begin
      km1 = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        src_a   = a;
        src_b   = b;
        src_c   = cin;
        src_sum = '0;
        src_v   = in_valid;
        ld      = in_ready;
      end else begin
        src_a   = a_q[km1];
        src_b   = b_q[km1];
        src_c   = carry_q[km1];
        src_sum = sum_q[km1];
        src_v   = valid_q[km1];
        ld      = adv[km1];
      end
      slice = {1'b0, src_a[k*SW +: SW]} + {1'b0, src_b[k*SW +: SW]} + {{SW{1'b0}}, src_c};
      // Data only moves with a valid beat so an emptied stage keeps quiet registers.
      if (ld) begin
        valid_d[k] = src_v;
        if (src_v) begin
          a_d[k]                = src_a;
          b_d[k]                = src_b;
          sum_d[k]              = src_sum;
          sum_d[k][k*SW +: SW]  = slice[SW-1:0];
          carry_d[k]            = slice[SW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    carry_q <= carry_d;
    a_q     <= a_d;
    b_q     <= b_d;
    sum_q   <= sum_d;
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = out_valid ? sum_q[STAGES-1] : '0;
  assign cout      = out_valid && carry_q[STAGES-1];
  assign ovf       = out_valid && (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                     (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: 32/4 instance with timing-aware queue model and directed vectors,
// plus exhaustive 4/2 and 3/1 instances under random backpressure.
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  logic       s_rst, s_done, s_drain;
  logic       s4_iv, s4_ir, s4_cin, s4_ov, s4_or, s4_cout, s4_ovf;
  logic [3:0] s4_a, s4_b, s4_sum;
  logic       s3_iv, s3_ir, s3_cin, s3_ov, s3_or, s3_cout, s3_ovf;
  logic [2:0] s3_a, s3_b, s3_sum;

  pipelined_adder #(.WIDTH(4), .STAGES(2)) dut4 (
    .clk(clk), .rst(s_rst), .in_valid(s4_iv), .in_ready(s4_ir), .a(s4_a), .b(s4_b),
    .cin(s4_cin), .out_valid(s4_ov), .out_ready(s4_or), .sum(s4_sum), .cout(s4_cout),
    .ovf(s4_ovf)
  );

  pipelined_adder #(.WIDTH(3), .STAGES(1)) dut3 (
    .clk(clk), .rst(s_rst), .in_valid(s3_iv), .in_ready(s3_ir), .a(s3_a), .b(s3_b),
    .cin(s3_cin), .out_valid(s3_ov), .out_ready(s3_or), .sum(s3_sum), .cout(s3_cout),
    .ovf(s3_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_s4     = 0;
  int n_s3     = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned sum/carry plus true signed overflow, cin counted as +1.
  typedef struct packed { logic ov; logic co; logic [63:0] s; } res_t;

  function automatic res_t model(input int w, input longint unsigned x, input longint unsigned y,
                                 input logic c);
    res_t             r;
    longint unsigned  full;
    longint           sx, sy, ssum, lim;
    full = x + y + longint'(c);
    lim  = longint'(64'd1 << (w - 1));
    sx   = (x >= 64'(lim)) ? longint'(x) - 2 * lim : longint'(x);
    sy   = (y >= 64'(lim)) ? longint'(y) - 2 * lim : longint'(y);
    ssum = sx + sy + longint'(c);
    r.s  = full & ((64'd1 << w) - 1);
    r.co = full[w];
    r.ov = (ssum > lim - 1) || (ssum < -lim);
    return r;
  endfunction

  // Main scoreboard: every queued beat must surface exactly S cycles after acceptance
  // unless it is queued behind a stalled head.
  typedef struct { logic [W+1:0] r; int t; } ent_t;
  ent_t q[$];

  initial begin
    logic exp_v;
    res_t rr;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
      end else begin
        exp_v = (q.size() > 0) && (cyc >= q[0].t + S);
        check("out_valid", 66'(out_valid), 66'(exp_v));
        check("in_ready", 66'(in_ready), 66'((q.size() < S) || out_ready));
        if (exp_v) check("result", 66'({ovf, cout, sum}), 66'(q[0].r));
        else       check("idle outputs zero", 66'({ovf, cout, sum}), 66'(0));
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() > 0) void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          rr = model(W, 64'(a), 64'(b), cin);
          q.push_back('{r: {rr.ov, rr.co, rr.s[W-1:0]}, t: cyc});
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      output bit first_try);
    int n;
    bit hs;
    n = 0;
    a = x; b = y; cin = c; in_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 200);
    in_valid  = 1'b0;
    first_try = (n == 1);
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL send timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  // Called right after send: outputs must stay idle until exactly lat cycles after acceptance.
  task automatic expect_out(input string name, input int lat, input logic [W-1:0] es,
                            input logic ec, input logic eo);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i < lat) begin
        check({name, " early out_valid"}, 66'(out_valid), 66'(0));
      end else begin
        check({name, " out_valid"}, 66'(out_valid), 66'(1));
        check({name, " sum"}, 66'(sum), 66'(es));
        check({name, " cout"}, 66'(cout), 66'(ec));
        check({name, " ovf"}, 66'(ovf), 66'(eo));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ft, all_first, hs;
    int n0, acc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 66'(out_valid), 66'(0));
    check("reset sum", 66'(sum), 66'(0));
    check("reset in_ready", 66'(in_ready), 66'(1));
    @(posedge clk);
    #1;

    send(32'h0000_0005, 32'h0000_0003, 1'b0, ft);
    expect_out("basic", S, 32'h0000_0008, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, ft);
    expect_out("ripple", S, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ft);
    expect_out("pos ovf", S, 32'h8000_0000, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, ft);
    expect_out("neg ovf", S, 32'h0000_0000, 1'b1, 1'b1);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b1, ft);
    expect_out("mid carry", S, 32'h0001_0001, 1'b0, 1'b0);

    // Throughput: back-to-back beats must each be taken on the first try.
    n0 = n_out;
    all_first = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ft);
      all_first &= ft;
    end
    check("throughput in_ready", 66'(all_first), 66'(1));
    repeat (S + 2) @(posedge clk);
    #1;
    check("throughput count", 66'(n_out - n0), 66'(100));

    // Backpressure: a blocked output lets the pipe fill to S beats, then stalls intake.
    out_ready = 1'b0;
    acc = 0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        acc++;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    check("bp accepted", 66'(acc), 66'(S));
    @(negedge clk);
    check("bp in_ready low", 66'(in_ready), 66'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (S + 2) @(posedge clk);
    #1;
    check("bp drained", 66'(n_out - n0), 66'(S));

    // Reset with three beats in flight: none may ever emerge.
    n0 = n_out;
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'b0, ft);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid reset out_valid", 66'(out_valid), 66'(0));
    check("mid reset sum", 66'(sum), 66'(0));
    check("mid reset cout", 66'(cout), 66'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post reset in_ready", 66'(in_ready), 66'(1));
    repeat (10) @(posedge clk);
    #1;
    check("reset discarded beats", 66'(n_out - n0), 66'(0));

    fork
      wait (s_done);
      repeat (20000) @(posedge clk);
    join_any
    disable fork;
    check("small configs done", 66'(s_done), 66'(1));
    check("s4 all results", 66'(n_s4), 66'(512));
    check("s3 all results", 66'(n_s3), 66'(128));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Exhaustive small configurations.
  initial begin
    s_rst = 1'b1; s_done = 1'b0; s_drain = 1'b0;
    s4_iv = 1'b0; s4_a = '0; s4_b = '0; s4_cin = 1'b0;
    s3_iv = 1'b0; s3_a = '0; s3_b = '0; s3_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 s_rst = 1'b0;
    fork
      begin
        int n;
        bit hs;
        for (int v = 0; v < 512; v++) begin
          {s4_a, s4_b, s4_cin} = 9'(v);
          s4_iv = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            hs = s4_ir;
            @(posedge clk);
            #1;
            n++;
          end while (!hs && n < 100);
          if (!hs) check("s4 accept timeout", 66'(hs), 66'(1));
        end
        s4_iv = 1'b0;
      end
      begin
        int n;
        bit hs;
        for (int v = 0; v < 128; v++) begin
          {s3_a, s3_b, s3_cin} = 7'(v);
          s3_iv = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            hs = s3_ir;
            @(posedge clk);
            #1;
            n++;
          end while (!hs && n < 100);
          if (!hs) check("s3 accept timeout", 66'(hs), 66'(1));
        end
        s3_iv = 1'b0;
      end
    join
    s_drain = 1'b1;
    repeat (10) @(posedge clk);
    #1 s_done = 1'b1;
  end

  initial begin
    s4_or = 1'b1;
    s3_or = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s4_or = s_drain | 1'($urandom_range(0, 1));
      s3_or = s_drain | 1'($urandom_range(0, 1));
    end
  end

  logic [5:0] q4[$];
  logic [4:0] q3[$];

  initial begin
    res_t rr;
    forever begin
      @(negedge clk);
      if (s_rst) begin
        q4.delete();
        q3.delete();
      end else begin
        check("s4 in_ready", 66'(s4_ir), 66'((q4.size() < 2) || s4_or));
        if (s4_ov) check("s4 result", 66'({s4_ovf, s4_cout, s4_sum}),
                         (q4.size() > 0) ? 66'(q4[0]) : 66'('1));
        else       check("s4 idle zero", 66'({s4_ovf, s4_cout, s4_sum}), 66'(0));
        if (s4_ov && s4_or) begin
          n_s4++;
          if (q4.size() > 0) void'(q4.pop_front());
        end
        if (s4_iv && s4_ir) begin
          rr = model(4, 64'(s4_a), 64'(s4_b), s4_cin);
          q4.push_back({rr.ov, rr.co, rr.s[3:0]});
        end
        check("s3 in_ready", 66'(s3_ir), 66'((q3.size() < 1) || s3_or));
        if (s3_ov) check("s3 result", 66'({s3_ovf, s3_cout, s3_sum}),
                         (q3.size() > 0) ? 66'(q3[0]) : 66'('1));
        else       check("s3 idle zero", 66'({s3_ovf, s3_cout, s3_sum}), 66'(0));
        if (s3_ov && s3_or) begin
          n_s3++;
          if (q3.size() > 0) void'(q3.pop_front());
        end
        if (s3_iv && s3_ir) begin
          rr = model(3, 64'(s3_a), 64'(s3_b), s3_cin);
          q3.push_back({rr.ov, rr.co, rr.s[2:0]});
        end
      end
    end
  end

endmodule
